// File: rtl/io_map_pkg.sv
// Shared IO register map and master identifiers for the IO bus arbiter and its peripherals.
package io_map_pkg;

  localparam logic [7:0] ADDR_SW       = 8'h04;
  localparam logic [7:0] ADDR_SEG_RDY  = 8'h08;
  localparam logic [7:0] ADDR_SEG_DATA = 8'h0C;
  localparam logic [7:0] ADDR_SW_VLD   = 8'h10;
  localparam logic [7:0] ADDR_SW_DATA  = 8'h14;
  localparam logic [7:0] ADDR_CNT      = 8'h18;
  localparam logic [7:0] ADDR_BTN_VLD  = 8'h1C;
  localparam logic [7:0] ADDR_BTN_DATA = 8'h20;

  typedef enum logic {
    M_CPU = 1'b0,
    M_DBG = 1'b1
  } mst_e;

  function automatic mst_e other(input mst_e m);
    return (m == M_CPU) ? M_DBG : M_CPU;
  endfunction

endpackage

// File: rtl/io_arb_rr.sv
// Two-way round-robin arbiter with bounded lock: the last locked owner keeps the bus
// until it drops lock or has taken LOCK_MAX grants in a row while the other master waits.
module io_arb_rr
  import io_map_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  mst_e             ptr, ptr_next, owner, winner;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
  logic             own_wins, any_gnt;

  // ptr names the master with round-robin priority, so the last owner is always the other one.
  assign owner = other(ptr);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    gnt           = '0;
    ptr_next      = ptr;
    lock_cnt_next = '0;
    own_wins      = req[owner] && (!req[ptr] || (lock_cnt != '0 && lock_cnt != CNT_MAX));
    winner        = own_wins ? owner : ptr;
    any_gnt       = rstn && (req != 2'b00);
    if (any_gnt) begin
      gnt[winner] = 1'b1;
      ptr_next    = other(winner);
      if (lock[winner]) begin
        if (winner != owner)
          lock_cnt_next = CNT_W'(1);
        else
          lock_cnt_next = (lock_cnt == CNT_MAX) ? CNT_MAX : lock_cnt + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr      <= M_CPU;
      lock_cnt <= '0;
    end else begin
      ptr      <= ptr_next;
      lock_cnt <= lock_cnt_next;
    end
  end

endmodule

// File: rtl/io_arb.sv
// IO bus arbiter for CPU (m0) and debug console (m1): one registered bus transaction per
// grant, read data returned to the requesting master two cycles after its grant.
module io_arb
  import io_map_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvld,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvld,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_dout,
  output logic              io_we,
  output logic              io_rd,
  input  logic [DATA_W-1:0] io_din
);

  logic [1:0]        gnt;
  logic              any_gnt;
  mst_e              win, rd_mst;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  io_arb_rr #(.LOCK_MAX(LOCK_MAX)) u_rr (
    .clk  (clk),
    .rstn (rstn),
    .req  ({m1_req, m0_req}),
    .lock ({m1_lock, m0_lock}),
    .gnt  (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign any_gnt   = gnt[0] | gnt[1];
  assign win       = gnt[1] ? M_DBG : M_CPU;
  assign sel_we    = (win == M_DBG) ? m1_we    : m0_we;
  assign sel_addr  = (win == M_DBG) ? m1_addr  : m0_addr;
  assign sel_wdata = (win == M_DBG) ? m1_wdata : m0_wdata;

  // Strobes are rebuilt from the grant every cycle, so each accepted transaction yields one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io_we   <= 1'b0;
      io_rd   <= 1'b0;
      io_addr <= '0;
      io_dout <= '0;
      rd_mst  <= M_CPU;
    end else begin
      io_we <= any_gnt && sel_we;
      io_rd <= any_gnt && !sel_we;
      if (any_gnt) begin
        io_addr <= sel_addr;
        io_dout <= sel_wdata;
        rd_mst  <= win;
      end
    end
  end

  // NOTE: read-data holding registers are reset too, because their value is visible on the ports.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m0_rvld  <= 1'b0;
      m1_rvld  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_rvld <= io_rd && (rd_mst == M_CPU);
      m1_rvld <= io_rd && (rd_mst == M_DBG);
      if (io_rd && rd_mst == M_CPU) m0_rdata <= io_din;
      if (io_rd && rd_mst == M_DBG) m1_rdata <= io_din;
    end
  end

endmodule

// File: tb/tb_io_arb.sv
// Self-checking bench for io_arb: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_io_arb;
  import io_map_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              m0_req, m0_we, m0_lock, m0_gnt, m0_rvld;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvld;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_dout, io_din;
  logic              io_we, io_rd;

  always #5 clk = ~clk;

  io_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvld(m0_rvld), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvld(m1_rvld), .m1_rdata(m1_rdata),
    .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd), .io_din(io_din)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       r0, r1, l0, l1, we0, we1;
    logic [1:0] gnt;     // {m1_gnt, m0_gnt}
    logic       we, rd;  // strobes in the following cycle
  } vec_t;

  typedef struct {
    bit                v;
    bit                we;
    int                m;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  // Reference model: arbitration history plus the two pipeline stages as transactions.
  int                last;
  int                run;
  txn_t              st_bus, st_ret;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_dout;
  logic [DATA_W-1:0] h_rdata [2];

  task automatic model_reset();
    last       = -1;
    run        = 0;
    st_bus     = '{default: 0};
    st_ret     = '{default: 0};
    h_addr     = '0;
    h_dout     = '0;
    h_rdata[0] = '0;
    h_rdata[1] = '0;
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (!r0 && r1)  return 1;
    if (last >= 0 && run > 0 && run < LOCK_MAX) return last;
    return (last == 0) ? 1 : 0;
  endfunction

  task automatic drive(input int m, input bit req, input bit we, input bit lock,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = data;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = data;
    end
  endtask

  task automatic clear_inputs();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    io_din = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", {io_we, io_rd, m0_gnt, m1_gnt, m0_rvld, m1_rvld,
                            io_addr, io_dout, m0_rdata, m1_rdata}, '0);
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus already on the inputs, checked against the model.
  task automatic model_cycle(output int w);
    txn_t       nxt, ret;
    logic [1:0] eg;
    bit         lk;
    #1;
    w  = pick(m0_req, m1_req);
    eg = 2'b00;
    if (w >= 0) eg[w] = 1'b1;
    check("rand_gnt", {m1_gnt, m0_gnt}, eg);
    nxt.v    = (w >= 0);
    nxt.m    = w;
    nxt.we   = (w == 1) ? m1_we    : m0_we;
    nxt.addr = (w == 1) ? m1_addr  : m0_addr;
    nxt.data = (w == 1) ? m1_wdata : m0_wdata;
    ret.v    = st_bus.v && !st_bus.we;
    ret.m    = st_bus.m;
    ret.we   = 1'b0;
    ret.addr = '0;
    ret.data = io_din;
    if (w < 0) begin
      run = 0;
    end else begin
      lk = (w == 1) ? m1_lock : m0_lock;
      if (lk) run = (w == last && run > 0) ? ((run < LOCK_MAX) ? run + 1 : LOCK_MAX) : 1;
      else    run = 0;
      last = w;
    end
    @(posedge clk); #1;
    st_bus = nxt;
    st_ret = ret;
    if (st_bus.v) begin
      h_addr = st_bus.addr;
      h_dout = st_bus.data;
    end
    if (st_ret.v) h_rdata[st_ret.m] = st_ret.data;
    check("rand_bus", {io_we, io_rd, io_addr, io_dout},
          {st_bus.v && st_bus.we, st_bus.v && !st_bus.we, h_addr, h_dout});
    check("rand_ret", {m1_rvld, m0_rvld, m1_rdata, m0_rdata},
          {st_ret.v && st_ret.m == 1, st_ret.v && st_ret.m == 0, h_rdata[1], h_rdata[0]});
  endtask

  vec_t vecs [12];

  initial begin
    int                w;
    bit                pend [2];
    bit                p_we [2];
    bit                p_lk [2];
    logic [ADDR_W-1:0] p_addr [2];
    logic [DATA_W-1:0] p_data [2];
    int                m1_left;
    bit                m0_done;
    int                i;

    //          r0 r1 l0 l1 we0 we1 gnt    we rd
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 2'b01, 0, 1};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 2'b10, 0, 1};
    vecs[2]  = '{1, 1, 0, 0, 0, 0, 2'b01, 0, 1};
    vecs[3]  = '{1, 1, 0, 0, 0, 0, 2'b10, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 1, 2'b10, 1, 0};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, 2'b01, 0, 1};
    vecs[7]  = '{1, 1, 1, 0, 0, 0, 2'b10, 0, 1};
    vecs[8]  = '{1, 1, 1, 0, 0, 0, 2'b01, 0, 1};
    vecs[9]  = '{1, 1, 1, 0, 1, 0, 2'b01, 1, 0};
    vecs[10] = '{1, 1, 0, 0, 0, 0, 2'b01, 0, 1};
    vecs[11] = '{1, 1, 0, 0, 0, 0, 2'b10, 0, 1};

    clear_inputs();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(0, vecs[k].r0, vecs[k].we0, vecs[k].l0, ADDR_SW, 32'h1000 + k);
      drive(1, vecs[k].r1, vecs[k].we1, vecs[k].l1, ADDR_CNT, 32'h2000 + k);
      #1;
      check($sformatf("vec%0d_gnt", k), {m1_gnt, m0_gnt}, vecs[k].gnt);
      @(posedge clk); #1;
      check($sformatf("vec%0d_strobe", k), {io_we, io_rd}, {vecs[k].we, vecs[k].rd});
    end
    clear_inputs();

    // Single read of switch data: strobe in N+1 only, data back in N+2.
    do_reset();
    drive(0, 1, 0, 0, ADDR_SW_DATA, '0);
    #1;
    check("rd_gnt", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, '0, '0);
    io_din = 32'hDEADBEEF;
    check("rd_strobe", {io_rd, io_we, io_addr}, {1'b1, 1'b0, ADDR_SW_DATA});
    @(posedge clk); #1;
    io_din = 32'h0;
    check("rd_return", {io_rd, m0_rvld, m1_rvld, m0_rdata}, {1'b0, 1'b1, 1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    check("rd_hold", {m0_rvld, m0_rdata}, {1'b0, 32'hDEADBEEF});

    // Single write of segment data: one write strobe, no read return.
    do_reset();
    drive(0, 1, 1, 0, ADDR_SEG_DATA, 32'h12345678);
    #1;
    check("wr_gnt", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, '0, '0);
    check("wr_strobe", {io_we, io_rd, io_addr, io_dout}, {1'b1, 1'b0, ADDR_SEG_DATA, 32'h12345678});
    @(posedge clk); #1;
    check("wr_after", {io_we, io_rd, m0_rvld, io_addr, io_dout}, {1'b0, 1'b0, 1'b0, ADDR_SEG_DATA, 32'h12345678});
    @(posedge clk); #1;
    check("wr_no_rvld", {m0_rvld, m1_rvld}, 2'b00);

    // Locked debug reads: 16 in a row, one CPU slot, then debug resumes.
    do_reset();
    m1_left = 20;
    m0_done = 1'b0;
    i       = 0;
    while (m1_left > 0 && i < 30) begin
      drive(1, 1, 0, 1, ADDR_CNT, '0);
      drive(0, (i >= 1) && !m0_done, 0, 0, ADDR_SW, '0);
      #1;
      check($sformatf("lock_gnt%0d", i), {m1_gnt, m0_gnt}, (i == 16) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      check($sformatf("lock_strobe%0d", i), {io_rd, io_we, io_addr},
            {1'b1, 1'b0, (i == 16) ? ADDR_SW : ADDR_CNT});
      if (i == 16) m0_done = 1'b1;
      else         m1_left--;
      i++;
    end
    clear_inputs();

    // Reset during the strobe cycle of a read aborts it for good.
    do_reset();
    drive(0, 1, 0, 0, ADDR_BTN_DATA, '0);
    #1;
    check("abort_gnt", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1;
    check("abort_strobe", io_rd, 1'b1);
    io_din = 32'hA5A5A5A5;
    rstn   = 1'b0;
    #1;
    check("abort_in_reset", {io_rd, io_we, m0_rvld, m0_gnt, m1_gnt}, 5'b0);
    drive(0, 0, 0, 0, '0, '0);
    @(posedge clk); #1;
    check("abort_no_rvld", {m0_rvld, m0_rdata, io_rd}, '0);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_quiet%0d", k), {io_rd, io_we, m0_rvld, m1_rvld}, 4'b0);
    end
    drive(0, 1, 0, 0, ADDR_SW, '0);
    drive(1, 1, 0, 0, ADDR_SW, '0);
    #1;
    check("abort_ptr_m0", {m1_gnt, m0_gnt}, 2'b01);
    clear_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    pend[0] = 0;
    pend[1] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 9) != 0) begin
          pend[m]   = 1;
          p_we[m]   = ($urandom_range(0, 2) == 0);
          p_lk[m]   = ($urandom_range(0, 3) != 0);
          p_addr[m] = ADDR_W'($urandom_range(0, 8) * 4);
          p_data[m] = $urandom;
        end
        if (pend[m]) drive(m, 1, p_we[m], p_lk[m], p_addr[m], p_data[m]);
        else         drive(m, 0, 0, 0, ADDR_W'($urandom), $urandom);
      end
      io_din = $urandom;
      model_cycle(w);
      if (w >= 0) pend[w] = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
